// File: rtl/wb_pkg.sv
// Shared Wishbone B4 burst types and the wrapped burst-address helper.
// Any burst-capable target can reuse wb_burst_next.
package wb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } wb_bte_e;

  localparam int WB_IDX_W = 32;
  typedef logic [WB_IDX_W-1:0] wb_idx_t;

  // Only the low bits selected by the wrap size advance; callers truncate
  // the linear case to their own depth, which gives the natural wrap.
  function automatic wb_idx_t wb_burst_next(input wb_idx_t addr, input wb_bte_e bte);
    wb_idx_t mask;
    case (bte)
      WRAP4:   mask = wb_idx_t'(3);
      WRAP8:   mask = wb_idx_t'(7);
      WRAP16:  mask = wb_idx_t'(15);
      default: mask = '1;
    endcase
    return (addr & ~mask) | ((addr + wb_idx_t'(1)) & mask);
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, cti, bte, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cti, bte, cyc, stb, we,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_slave_mem.sv
// Single-port synchronous RAM, per-byte write enable, one-cycle read latency.
// Kept separate so a vendor macro can replace it without touching the FSM.
module wb_sram_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM target: classic cycles, constant and
// incrementing (linear / wrap-4/8/16) bursts with one ACK per strobed beat.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter     INIT_FILE     = ""
) (
  input logic clk,
  input logic rst,
  wb_if.slave s
);
  // state  | meaning
  // IDLE   | waiting for CYC&STB; RAM reads the ADR word speculatively
  // SINGLE | classic cycle: ACK (and byte write) this cycle
  // BURST  | ACK every strobed beat, address from internal counter
  // ERROR  | reserved CTI: ERR for one cycle, no write

  localparam int NB = WB_DATA_WIDTH / 8;
  localparam int WS = $clog2(NB);

  typedef logic [MEM_ADDR_BITS-1:0] word_t;
  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERROR} state_e;

  state_e state, state_nxt;
  word_t  cnt, cnt_nxt;
  word_t  adr_word, beat_next, ram_addr;
  logic   ram_we;
  logic   ack, err;
  logic   cti_single, cti_burst;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;
  logic   unused_adr_bits;

  assign adr_word        = s.adr[MEM_ADDR_BITS+WS-1:WS];
  assign unused_adr_bits = ^{s.adr[WB_ADDR_WIDTH-1:MEM_ADDR_BITS+WS], s.adr[WS-1:0]};

  assign cti_single = (s.cti == CLASSIC) || (s.cti == EOB);
  assign cti_burst  = (s.cti == CONST)   || (s.cti == INCR);

  assign beat_next = (s.cti == CONST) ? cnt
                   : word_t'(wb_burst_next(wb_idx_t'(cnt), wb_bte_e'(s.bte)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_addr  = adr_word;
    ram_we    = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (s.cyc && s.stb) begin
          cnt_nxt = adr_word;
          if (cti_single)     state_nxt = SINGLE;
          else if (cti_burst) state_nxt = BURST;
          else                state_nxt = ERROR;
        end
      end
      SINGLE: begin
        ack       = s.cyc && s.stb;
        ram_addr  = cnt;
        ram_we    = ack && s.we;
        state_nxt = IDLE;
      end
      BURST: begin
        ram_addr = cnt;
        if (!s.cyc) begin
          state_nxt = IDLE;
        end else if (s.stb) begin
          ack     = 1'b1;
          cnt_nxt = beat_next;
          // single-port RAM: a write beat owns the port, a read beat prefetches
          if (s.we) ram_we   = 1'b1;
          else      ram_addr = beat_next;
          if (s.cti == EOB) state_nxt = IDLE;
        end
      end
      ERROR: begin
        err       = s.cyc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  wb_sram_slave_mem #(
    .DATA_WIDTH (WB_DATA_WIDTH),
    .ADDR_BITS  (MEM_ADDR_BITS),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (s.sel),
    .wdata (s.dat_w),
    .rdata (ram_rdata)
  );

  assign s.ack   = ack;
  assign s.err   = err;
  assign s.dat_r = ack ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: directed protocol cases plus random
// singles and bursts checked against a word-array memory model.
module tb_wb_sram_slave;
  import wb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAB = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_sram_slave #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .MEM_ADDR_BITS (MAB),
    .INIT_FILE     ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [1024];
  logic [31:0] bw_dat [16];
  logic [3:0]  bw_sel [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // word touched by beat i of a burst, from the wrap-block arithmetic
  function automatic int addr_of(input int start, input logic [1:0] bte,
                                 input bit is_const, input int i);
    int n;
    if (is_const) return start;
    case (bte)
      2'd0:    n = 1024;
      2'd1:    n = 4;
      2'd2:    n = 8;
      default: n = 16;
    endcase
    return (start - start % n) + (start % n + i) % n;
  endfunction

  task automatic bus_idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.cti = 3'b000; bus.bte = 2'b00;
    bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
  endtask

  task automatic drive_beat(input int w, input bit we, input logic [31:0] d,
                            input logic [3:0] sel, input logic [2:0] cti,
                            input logic [1:0] bte);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.adr   = ($urandom() & 32'hFFFF_F000) | (32'(w) << 2);
    bus.dat_w = d;
    bus.sel   = sel;
    bus.cti   = cti;
    bus.bte   = bte;
  endtask

  task automatic single(input bit we, input int w, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] rd);
    int c;
    drive_beat(w, we, d, sel, CLASSIC, 2'b00);
    c = 0;
    @(negedge clk);
    while (!bus.ack && c < 8) begin
      @(posedge clk); #1;
      @(negedge clk);
      c++;
    end
    rd = bus.dat_r;
    chk("single_latency", 32'(c), 1);
    if (bus.ack) begin
      if (we) model[w] = merge(model[w], d, sel);
      else    chk("single_rdata", rd, model[w]);
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    chk("single_ack_once", 32'(bus.ack), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input int start, input logic [1:0] bte, input bit is_const,
                           input int n, input bit we, input int gap_at,
                           input int gap_len, input int abort_after);
    logic [2:0] cti;
    int w;
    cti = (n == 1) ? EOB : (is_const ? CONST : INCR);
    drive_beat(start, we, bw_dat[0], we ? bw_sel[0] : 4'hF, cti, bte);
    @(negedge clk);
    chk("burst_req_ack", 32'(bus.ack), 0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          bus.stb = 1'b0;
          @(negedge clk);
          chk("burst_wait_ack", 32'(bus.ack), 0);
        end
      end
      w   = addr_of(start, bte, is_const, i);
      cti = (i == n - 1) ? EOB : (is_const ? CONST : INCR);
      @(posedge clk); #1;
      drive_beat(w, we, bw_dat[i], we ? bw_sel[i] : 4'hF, cti, bte);
      @(negedge clk);
      chk("burst_ack", 32'(bus.ack), 1);
      if (we) model[w] = merge(model[w], bw_dat[i], bw_sel[i]);
      else    chk("burst_rdata", bus.dat_r, model[w]);
      if (i + 1 == abort_after) break;
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    chk("burst_end_ack", 32'(bus.ack), 0);
    @(posedge clk); #1;
  endtask

  task automatic fill_bw(input bit full_sel);
    for (int i = 0; i < 16; i++) begin
      bw_dat[i] = $urandom();
      bw_sel[i] = full_sel ? 4'hF : 4'($urandom_range(1, 15));
    end
  endtask

  // bus invariants, every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack_err_exclusive", 32'(bus.ack & bus.err), 0);
      if (!bus.ack) chk("dat_r_zero_no_ack", bus.dat_r, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int op, w, n, st;
    logic [1:0] bte;
    bit cst, wr;

    bus_idle();
    rst = 1'b1;
    #12 rst = 1'b0;
    #11 rst = 1'b1;
    #1;
    chk("reset_ack", 32'(bus.ack), 0);
    chk("reset_err", 32'(bus.err), 0);
    chk("reset_dat_r", bus.dat_r, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ack", 32'(bus.ack), 0);
    chk("post_reset_err", 32'(bus.err), 0);
    chk("post_reset_dat_r", bus.dat_r, 0);
    @(posedge clk); #1;
    bus.cyc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cyc_only_ack", 32'(bus.ack), 0);
      @(posedge clk); #1;
    end
    bus_idle();
    @(posedge clk); #1;

    // byte enables on a classic cycle
    single(1'b1, 4, 32'hDEADBEEF, 4'hF, rd);
    single(1'b1, 4, 32'h000000AA, 4'h1, rd);
    single(1'b0, 4, 32'h0, 4'hF, rd);
    chk("byte_enable_merge", rd, 32'hDEADBEAA);

    // linear: preload words 8..15, then read 8..11
    fill_bw(1'b1);
    run_burst(8, 2'b00, 1'b0, 8, 1'b1, -1, 0, -1);
    run_burst(8, 2'b00, 1'b0, 4, 1'b0, -1, 0, -1);

    // wrap-4 write from word 6 then read back individually
    for (int i = 0; i < 4; i++) begin
      bw_dat[i] = 32'(i + 1);
      bw_sel[i] = 4'hF;
    end
    run_burst(6, 2'b01, 1'b0, 4, 1'b1, -1, 0, -1);
    single(1'b0, 4, 0, 4'hF, rd); chk("wrap4_mem4", rd, 32'h3);
    single(1'b0, 5, 0, 4'hF, rd); chk("wrap4_mem5", rd, 32'h4);
    single(1'b0, 6, 0, 4'hF, rd); chk("wrap4_mem6", rd, 32'h1);
    single(1'b0, 7, 0, 4'hF, rd); chk("wrap4_mem7", rd, 32'h2);

    // master wait state after beat 2
    run_burst(8, 2'b00, 1'b0, 4, 1'b0, 2, 2, -1);

    // abort after beat 1 of a write burst
    fill_bw(1'b1);
    run_burst(12, 2'b00, 1'b0, 4, 1'b1, -1, 0, 1);
    single(1'b0, 12, 0, 4'hF, rd);
    single(1'b0, 13, 0, 4'hF, rd);
    single(1'b0, 14, 0, 4'hF, rd);

    // reserved CTI
    single(1'b1, 50, 32'h12345678, 4'hF, rd);
    drive_beat(50, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b011, 2'b00);
    @(negedge clk);
    chk("err_req_cycle", 32'(bus.err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_asserted", 32'(bus.err), 1);
    chk("err_no_ack", 32'(bus.ack), 0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    chk("err_one_cycle", 32'(bus.err), 0);
    @(posedge clk); #1;
    single(1'b0, 50, 0, 4'hF, rd);
    chk("err_mem_unchanged", rd, 32'h12345678);

    // reset during beat 2 of an 8-beat write burst
    fill_bw(1'b1);
    run_burst(40, 2'b00, 1'b0, 8, 1'b1, -1, 0, -1);
    fill_bw(1'b1);
    drive_beat(40, 1'b1, bw_dat[0], 4'hF, INCR, 2'b00);
    @(negedge clk);
    chk("rst_burst_req_ack", 32'(bus.ack), 0);
    @(posedge clk); #1;
    drive_beat(40, 1'b1, bw_dat[0], 4'hF, INCR, 2'b00);
    @(negedge clk);
    chk("rst_burst_beat1_ack", 32'(bus.ack), 1);
    model[40] = bw_dat[0];
    @(posedge clk); #1;
    drive_beat(41, 1'b1, bw_dat[1], 4'hF, INCR, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ack", 32'(bus.ack), 0);
    chk("rst_async_dat_r", bus.dat_r, 0);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 40; i < 48; i++) single(1'b0, i, 0, 4'hF, rd);

    // random traffic over words 64..127
    for (int b = 0; b < 4; b++) begin
      fill_bw(1'b1);
      run_burst(64 + 16 * b, 2'b00, 1'b0, 16, 1'b1, -1, 0, -1);
    end
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: single(1'b1, 64 + $urandom_range(0, 63), $urandom(), 4'($urandom_range(1, 15)), rd);
        1: single(1'b0, 64 + $urandom_range(0, 63), 0, 4'hF, rd);
        default: begin
          bte = 2'($urandom_range(0, 3));
          cst = ($urandom_range(0, 4) == 0);
          wr  = $urandom_range(0, 1) == 1;
          n   = $urandom_range(2, (bte == 2'b00) ? 8 : 16);
          st  = (bte == 2'b00) ? 64 + $urandom_range(0, 64 - n) : 64 + $urandom_range(0, 63);
          fill_bw(1'b0);
          w   = (op == 2) ? -1 : $urandom_range(1, n - 1);
          run_burst(st, bte, cst, n, wr, w, $urandom_range(1, 3), -1);
        end
      endcase
    end
    for (int i = 64; i < 128; i += 7) single(1'b0, i, 0, 4'hF, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
